// File: rtl/freq_gate_counter_if.sv
// Measurement bus of the gated pulse counter.
// The counter owns the result signals. The consumer side (display path or
// test harness) owns the raw input under measurement.
interface freq_gate_counter_if #(
    parameter int W = 23
);
    logic         signal;       // asynchronous input under measurement
    logic [W-1:0] count_value;  // edge count of the last completed window
    logic         count_valid;  // one-cycle strobe when count_value updates
    logic         overflow;     // last completed window saturated

    // Counter side: samples the raw signal and publishes results
    modport master (
        input  signal,
        output count_value,
        output count_valid,
        output overflow
    );

    // Consumer side: drives the raw signal and reads results
    modport slave (
        output signal,
        input  count_value,
        input  count_valid,
        input  overflow
    );
endinterface

// File: rtl/freq_gate_counter.sv
// Gated pulse counter for the frequency meter display path.
// The raw input passes through a three-flop synchronizer, and its rising
// edges are counted over a fixed window of GATE_CYCLES clocks. At the end of
// each window the saturated count is published together with a one-cycle
// valid strobe and an overflow flag. The published values stay put until the
// next window closes, so the consumer may sample them at any time.
module freq_gate_counter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int W           = 23
) (
    input  logic                clk,
    input  logic                rst,
    freq_gate_counter_if.master bus
);

    // Timer width: GATE_CYCLES is at least 4, so the width is at least 2 bits.
    localparam int              TW         = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(GATE_CYCLES - 1);
    localparam logic [W-1:0]    ACC_MAX    = {W{1'b1}};
    localparam logic [1:0]      ARM_DONE   = 2'd3;

    // Saturating add of a single-bit increment.
    // The result is {would_overflow, saturated_sum}. The sum never wraps.
    function automatic logic [W:0] sat_add1(input logic [W-1:0] a,
                                            input logic         inc);
        logic [W:0] res;
        if (inc && (a == ACC_MAX)) begin
            res = {1'b1, ACC_MAX};
        end else begin
            res = {1'b0, a + {{(W-1){1'b0}}, inc}};
        end
        return res;
    endfunction

    // Synchronizer chain. s3_r is the previous value of s2_r for edge detection.
    logic           s1_r;
    logic           s2_r;
    logic           s3_r;

    // Arming counter: masks the edge detector while the synchronizer
    // refills after reset, so a level held high through reset is not an edge.
    logic [1:0]     arm_cnt_r;

    // Window timer, accumulator and sticky saturation flag
    logic [TW-1:0]  timer_r;
    logic [W-1:0]   acc_r;
    logic           sat_r;

    // Published results
    logic [W-1:0]   count_value_r;
    logic           count_valid_r;
    logic           overflow_r;

    // Decoded per-cycle terms
    logic           armed_s;
    logic           edge_s;
    logic           gate_end_s;
    logic [W:0]     closing_s;

    // Decode armed state, the synchronized rising edge, end of window and the
    // closing count (accumulator plus an edge landing on the last cycle)
    always_comb begin
        armed_s    = 1'b0;
        edge_s     = 1'b0;
        gate_end_s = 1'b0;
        closing_s  = {(W+1){1'b0}};
        if (arm_cnt_r == ARM_DONE) begin
            armed_s = 1'b1;
        end else begin
            armed_s = 1'b0;
        end
        edge_s     = s2_r & ~s3_r & armed_s;
        gate_end_s = (timer_r == TIMER_LAST);
        closing_s  = sat_add1(acc_r, edge_s);
    end

    // Bring the asynchronous input into the clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= bus.signal;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Count the first three cycles after reset release, then hold at armed
    always_ff @(posedge clk) begin
        if (rst) begin
            arm_cnt_r <= 2'd0;
        end else if (arm_cnt_r != ARM_DONE) begin
            arm_cnt_r <= arm_cnt_r + 2'd1;
        end else begin
            arm_cnt_r <= arm_cnt_r;
        end
    end

    // Free-running gate timer: 0 .. GATE_CYCLES-1, then wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= {TW{1'b0}};
        end else if (gate_end_s) begin
            timer_r <= {TW{1'b0}};
        end else begin
            timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    // Accumulate edges inside the window. Saturate instead of wrapping and
    // remember that saturation happened. Restart empty when the window closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {W{1'b0}};
            sat_r <= 1'b0;
        end else if (gate_end_s) begin
            acc_r <= {W{1'b0}};
            sat_r <= 1'b0;
        end else if (edge_s) begin
            if (acc_r == ACC_MAX) begin
                acc_r <= acc_r;
                sat_r <= 1'b1;
            end else begin
                acc_r <= acc_r + {{(W-1){1'b0}}, 1'b1};
                sat_r <= sat_r;
            end
        end else begin
            acc_r <= acc_r;
            sat_r <= sat_r;
        end
    end

    // Publish the closing count and overflow once per window with a strobe.
    // An edge on the last cycle belongs to the closing window.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_value_r <= {W{1'b0}};
            count_valid_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else if (gate_end_s) begin
            count_value_r <= closing_s[W-1:0];
            count_valid_r <= 1'b1;
            overflow_r    <= sat_r | closing_s[W];
        end else begin
            count_value_r <= count_value_r;
            count_valid_r <= 1'b0;
            overflow_r    <= overflow_r;
        end
    end

    assign bus.count_value = count_value_r;
    assign bus.count_valid = count_valid_r;
    assign bus.overflow    = overflow_r;

endmodule

// File: doc/freq_gate_counter.md
# freq_gate_counter

Gated pulse counter that feeds the frequency meter's display path. It synchronizes the raw input `signal` and detects its rising edges. Edges are counted over a fixed gate window of `GATE_CYCLES` clock periods (1 s at the default clock). At the end of each window the block publishes a registered, saturating count with a one-cycle valid strobe and an overflow flag. The downstream binary-to-BCD/7-segment stage consumes `count_value` directly.

## Interface

Parameters:
- `GATE_CYCLES`, default 50_000_000: gate window length in clk cycles (1 s at 50 MHz); legal range ≥ 4.
- `W`, default 23: count width; must cover the maximum displayed value (999_999 needs 20 bits; 23 kept for margin).

Ports:
- `clk`  in  1: single system clock; all logic on rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `signal`  in  1: asynchronous external signal under measurement.
- `count_value`  out  W: rising-edge count of the last completed window, held until the next window completes.
- `count_valid`  out  1: one-cycle strobe, high in the cycle `count_value` updates.
- `overflow`  out  1: high if the last completed window saturated; updates together with `count_value`.

## Operation

- Synchronizer: `s1 <= signal`, `s2 <= s1`, `s3 <= s2`. The edge term is `s2 & ~s3 & armed`.
- Arm logic: a 2-bit counter holds `armed` low for the first 3 cycles after reset release. This prevents a signal held high through reset from producing a false edge.
- Gate timer: counts 0 … `GATE_CYCLES`-1, then wraps to 0. The cycle in which timer == `GATE_CYCLES`-1 is the window's last cycle ("gate_end").
- Accumulator `acc` (W bits) plus sticky flag `sat`:
  - On an edge in a non-gate_end cycle: if `acc` == 2^W-1, set `sat`; otherwise increment `acc`.
  - On gate_end: `count_value <= acc + edge`, saturated at 2^W-1. `overflow <= sat` OR (the edge would exceed 2^W-1). Clear `acc` and `sat` to 0. `count_valid <= 1`.
- An edge detected on the gate_end cycle is counted in the closing window, not the next one.
- `count_valid` is registered: high exactly one cycle per window, otherwise 0.
- No wrap-around of the count ever occurs; saturation always applies.
- The block is free-running, with no enable. The first valid result appears one full window after reset.

## Timing

- Reset values: `count_value`=0, `count_valid`=0, `overflow`=0. Also cleared: s1/s2/s3=0, timer=0, `acc`=0, `sat`=0, arm counter=0.
- Reset mid-window discards the partial count. The timer restarts at 0, so the next window is a full `GATE_CYCLES` long. Outputs read 0 until that window ends.
- Edge latency: `signal` rising before clk edge k sets s1 at k and s2 at k+1. It is counted into `acc` at k+2.
- First `count_valid` is at clock edge `GATE_CYCLES` after reset is released (timer reaches `GATE_CYCLES`-1 on cycle `GATE_CYCLES`-1, registered on the next edge). After that, `count_valid` repeats every `GATE_CYCLES` cycles exactly.
- Input constraint: high and low phases of `signal` each ≥ 2 clk periods for guaranteed counting, which gives a max reliable frequency of about clk/4. Faster inputs may under-count; there is no other failure.
- Measurement error: ±1 count per window from phase alignment. This is inherent to the method and not flagged.
- `count_value` and `overflow` are stable between strobes. The consumer may sample them at any time.

## Test plan

Use `GATE_CYCLES`=100 and `W`=8 unless stated otherwise.

1. **Reset:** assert `rst` 5 cycles with `signal` toggling → `count_value`=0, `count_valid`=0, `overflow`=0 throughout reset and until the first gate_end. First strobe occurs at cycle 100 after release.
2. **Steady input:** `signal` period 10 clk (5 high/5 low), started in phase → every window after the first reports `count_value`=10, `overflow`=0. `count_valid` is high for exactly 1 cycle every 100 cycles.
3. **Saturation:** `W`=4, period 4 clk → `count_value`=15, `overflow`=1. Then switch to period 20 clk → next full window `count_value`=5, `overflow`=0.
4. **Window boundary:** place a single rising edge so that it is detected on the gate_end cycle → counted in the closing window (`count_value`=1). The following window reports 0.
5. **Reset mid-window:** 50 cycles of period-10 input, then 1-cycle `rst` → outputs 0. The next strobe comes 100 cycles after release with `count_value`=10.
6. **High through reset:** hold `signal`=1 across reset and for the whole window → `count_value`=0; no false edge.
